// File: rtl/sha256_stream_core.sv
// SHA-256 compression engine that chains hash state across pre-padded 512-bit blocks.
// Define SHA224_MODE_EN to add the i_mode port and SHA-224 IV and truncated output.
module sha256_stream_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CNT_W            = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [511:0]     i_block,
    input  logic             i_first,
    input  logic             i_last,
`ifdef SHA224_MODE_EN
    input  logic             i_mode,
`endif
    output logic             o_busy,
    output logic             o_digest_valid,
    output logic [255:0]     o_digest,
    output logic [CNT_W-1:0] o_block_cnt
);
    localparam int R = ROUNDS_PER_CYCLE;

    generate
        if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_rounds
            $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COMPRESS = 2'd1;
    localparam logic [1:0] UPDATE   = 2'd2;

    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA224_MODE_EN
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [1:0]   state;
    logic [5:0]   rnd;
    logic [255:0] h;
    logic [255:0] work;
    logic [255:0] work_nxt;
    logic [255:0] sum;
    logic [255:0] iv_sel;
    logic [31:0]  w     [16];
    logic [31:0]  w_nxt [16];
    logic         last_flag;
    logic         done_p0;
    logic         mode;
    logic         accept;

    assign o_ready = (state == IDLE);
    assign o_busy  = ~o_ready;
    assign accept  = i_valid && o_ready;

`ifdef SHA224_MODE_EN
    assign iv_sel = i_mode ? IV224 : IV256;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode <= 1'b0;
        end else if (accept && i_first) begin
            mode <= i_mode;
        end
    end
`else
    assign iv_sel = IV256;
    assign mode   = 1'b0;
`endif

    // R rounds per cycle; the window is extended by R scheduled words and then shifted by R
    always_comb begin
        logic [31:0] ext [16+R];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        t1 = '0;
        t2 = '0;
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int i = 16; i < 16 + R; i++) begin
            ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
        end
        {a, b, c, d, e, f, g, hh} = work;
        for (int j = 0; j < R; j++) begin
            t1 = hh + bsig1(e) + ((e & f) ^ (~e & g)) + K[rnd + 6'(j)] + ext[j];
            t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g;  g = f;  f = e;  e = d + t1;
            d  = c;  c = b;  b = a;  a = t1 + t2;
        end
        work_nxt = {a, b, c, d, e, f, g, hh};
        for (int i = 0; i < 16; i++) w_nxt[i] = ext[i+R];
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[255-32*i -: 32] = h[255-32*i -: 32] + work[255-32*i -: 32];
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            work <= i_first ? iv_sel : h;
            for (int i = 0; i < 16; i++) w[i] <= i_block[511-32*i -: 32];
        end else if (state == COMPRESS) begin
            work <= work_nxt;
            w    <= w_nxt;
        end
    end

    // UPDATE folds the working state into H; the digest is registered one edge later
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            rnd            <= '0;
            h              <= IV256;
            last_flag      <= 1'b0;
            done_p0        <= 1'b0;
            o_digest_valid <= 1'b0;
            o_digest       <= '0;
            o_block_cnt    <= '0;
        end else begin
            o_digest_valid <= done_p0;
            done_p0        <= 1'b0;
            if (done_p0) begin
                o_digest <= mode ? {h[255:32], 32'h0} : h;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (i_first) h <= iv_sel;
                        last_flag <= i_last;
                        if (i_first) begin
                            o_block_cnt <= CNT_W'(1);
                        end else if (o_block_cnt != '1) begin
                            o_block_cnt <= o_block_cnt + 1'b1;
                        end
                        state <= COMPRESS;
                    end
                end
                COMPRESS: begin
                    rnd <= rnd + 6'(R);
                    if (rnd == 6'(64 - R)) state <= UPDATE;
                end
                UPDATE: begin
                    h       <= sum;
                    done_p0 <= last_flag;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Self-checking bench for sha256_stream_core: known vectors, random chains against a
// behavioural SHA-256 model, backpressure, reset abort and a ROUNDS_PER_CYCLE sweep.
module tb_sha256_stream_core;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] ABC     = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] TWO_B1  = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid = 1'b0;
    logic         sw_valid = 1'b0;
    logic         first = 1'b0;
    logic         last = 1'b0;
    logic [511:0] blk = '0;
`ifdef SHA224_MODE_EN
    logic         mode = 1'b0;
`endif
    logic         ready, busy, dv;
    logic [255:0] dig;
    logic [2:0]   cnt;
    logic         sw_ready [3];
    logic         sw_busy  [3];
    logic         sw_dv    [3];
    logic [255:0] sw_dg    [3];
    logic [15:0]  sw_cnt   [3];

    int           errors = 0;
    int           checks = 0;
    int           pulses = 0;
    logic [255:0] mh = IV;
    int           mcnt = 0;

    always #5 clk = ~clk;
    always @(posedge dv) pulses++;

    sha256_stream_core #(.ROUNDS_PER_CYCLE(1), .CNT_W(3)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_block(blk),
        .i_first(first), .i_last(last),
`ifdef SHA224_MODE_EN
        .i_mode(mode),
`endif
        .o_busy(busy), .o_digest_valid(dv), .o_digest(dig), .o_block_cnt(cnt)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        sha256_stream_core #(.ROUNDS_PER_CYCLE(2 << g), .CNT_W(16)) u_sw (
            .i_clk(clk), .i_rst(rst), .i_valid(sw_valid), .o_ready(sw_ready[g]), .i_block(blk),
            .i_first(first), .i_last(last),
`ifdef SHA224_MODE_EN
            .i_mode(mode),
`endif
            .o_busy(sw_busy[g]), .o_digest_valid(sw_dv[g]), .o_digest(sw_dg[g]), .o_block_cnt(sw_cnt[g])
        );
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression: full 64-word schedule up front, then the textbook round loop
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] b);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a block on the main core and return just after its accept edge
    task automatic send(input logic [511:0] b, input logic f, input logic l);
        int waited;
        @(negedge clk);
        blk = b; first = f; last = l; valid = 1'b1;
        waited = 0;
        while (!ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) chk("ready_timeout", 256'(ready), 256'(1));
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_digest(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!dv && lat < 300);
    endtask

    task automatic do_block(input logic [511:0] b, input logic f, input logic l);
        int lat, p0;
        if (f) mh = IV;
        mcnt = f ? 1 : (mcnt < 7 ? mcnt + 1 : 7);
        mh = compress(mh, b);
        p0 = pulses;
        send(b, f, l);
        chk("block_cnt", 256'(cnt), 256'(mcnt));
        if (l) begin
            wait_digest(lat);
            chk("chain_latency", 256'(lat), 256'd66);
            chk("chain_digest", dig, mh);
        end else begin
            repeat (67) @(posedge clk);
            #1 chk("no_pulse_nonlast", 256'(pulses), 256'(p0));
        end
    endtask

    task automatic sweep(input logic [511:0] b, input logic [255:0] exp);
        int lat [3];
        logic [255:0] got [3];
        for (int g = 0; g < 3; g++) lat[g] = -1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) chk("sweep_ready", 256'(sw_ready[g]), 256'(1));
        blk = b; first = 1'b1; last = 1'b1; sw_valid = 1'b1;
        @(posedge clk);
        #1 sw_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("sweep_busy", 256'(sw_busy[g]), 256'(1));
            chk("sweep_cnt", 256'(sw_cnt[g]), 256'(1));
        end
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (sw_dv[g] && lat[g] < 0) begin
                    lat[g] = n;
                    got[g] = sw_dg[g];
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            chk("sweep_latency", 256'(lat[g]), 256'(64 / (2 << g) + 2));
            chk("sweep_digest", got[g], exp);
        end
    endtask

    initial begin
        int lat, p0;
        logic [511:0] rb;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 256'(ready), 256'(1));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_dvalid", 256'(dv), 256'(0));
        chk("rst_digest", dig, 256'h0);
        chk("rst_cnt", 256'(cnt), 256'(0));

        // single-block "abc"
        send(ABC, 1'b1, 1'b1);
        chk("abc_cnt", 256'(cnt), 256'(1));
        wait_digest(lat);
        chk("abc_latency", 256'(lat), 256'd66);
        chk("abc_digest", dig, ABC_DIG);
        @(posedge clk);
        #1 chk("abc_pulse_width", 256'(dv), 256'(0));
        chk("abc_digest_hold", dig, ABC_DIG);

        // two-block message with the second block held under backpressure
        p0 = pulses;
        send(TWO_B1, 1'b1, 1'b0);
        chk("two_cnt1", 256'(cnt), 256'(1));
        @(negedge clk);
        blk = TWO_B2; first = 1'b0; last = 1'b1; valid = 1'b1;
        repeat (5) begin
            chk("bp_ready", 256'(ready), 256'(0));
            chk("bp_busy", 256'(busy), 256'(1));
            @(negedge clk);
        end
        chk("bp_cnt_held", 256'(cnt), 256'(1));
        lat = 0;
        while (!ready && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1 valid = 1'b0;
        chk("two_cnt2", 256'(cnt), 256'(2));
        wait_digest(lat);
        chk("two_latency", 256'(lat), 256'd66);
        chk("two_digest", dig, TWO_DIG);
        chk("two_pulses", 256'(pulses - p0), 256'(1));

        // reset asserted at round 30 of an "abc" compression
        send(ABC, 1'b1, 1'b1);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_ready", 256'(ready), 256'(1));
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_cnt", 256'(cnt), 256'(0));
        chk("abort_digest", dig, 256'h0);
        p0 = pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(posedge clk);
        #1 chk("abort_no_pulse", 256'(pulses), 256'(p0));
        send(ABC, 1'b0, 1'b1);
        chk("abort_cnt_after", 256'(cnt), 256'(1));
        wait_digest(lat);
        chk("abort_latency", 256'(lat), 256'd66);
        chk("abort_iv_digest", dig, ABC_DIG);

        // random framing, including mid-message restarts
        for (int i = 0; i < 10; i++) begin
            do_block(rand_blk(), (i == 0) || ($urandom_range(0, 3) == 0),
                     (i == 9) || ($urandom_range(0, 2) == 0));
        end

        // long chain drives the 3-bit counter into saturation
        for (int i = 0; i < 9; i++) begin
            do_block(rand_blk(), i == 0, i == 8);
        end

        sweep(ABC, ABC_DIG);
        rb = rand_blk();
        sweep(rb, compress(IV, rb));

`ifdef SHA224_MODE_EN
        mode = 1'b1;
        send(ABC, 1'b1, 1'b1);
        mode = 1'b0;
        wait_digest(lat);
        chk("sha224_latency", 256'(lat), 256'd66);
        chk("sha224_digest", dig, {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
